// File: rtl/memory_access_unit_if.sv
// Request/response and memory-bus bundle for memory_access_unit.
// slave: the unit's side; master: the control unit plus main memory.
interface memory_access_unit_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_error;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_write_enable;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
      output req_ready, rsp_valid, rsp_data, rsp_error, mem_addr, mem_data_in, mem_write_enable
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out,
      input  req_ready, rsp_valid, rsp_data, rsp_error, mem_addr, mem_data_in, mem_write_enable
   );
endinterface

// File: rtl/memory_access_unit.sv
// Single-outstanding load/store initiator holding MAR/MBR for the main memory.
// Optional MEM_ADDR_CHECK_EN: fault out-of-range addresses instead of aliasing them.
module memory_access_unit #(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned MEM_DEPTH = 16384
) (
   input logic                  clk,
   input logic                  reset_n,
   memory_access_unit_if.slave  bus
);

   typedef enum logic [2:0] {StIdle, StWrite, StRdAddr, StRdCapt, StDone} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] mar_q;
   logic [DATA_W-1:0] mbr_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              mem_we_q;
   logic              addr_fault;

`ifdef MEM_ADDR_CHECK_EN
   localparam logic [ADDR_W:0] DepthW = (ADDR_W+1)'(MEM_DEPTH);
   logic err_q;

   assign addr_fault    = ({1'b0, bus.req_addr} >= DepthW);
   assign bus.rsp_error = err_q;
`else
   // Depth is a power of two, so the modulo is a mask of the low bits.
   localparam logic [ADDR_W-1:0] AddrMask = ADDR_W'(MEM_DEPTH - 1);

   assign addr_fault    = 1'b0;
   assign bus.rsp_error = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         mar_q       <= '0;
         mbr_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  req_ready_q <= 1'b0;
                  mbr_q       <= bus.req_wdata;
`ifdef MEM_ADDR_CHECK_EN
                  mar_q       <= bus.req_addr;
                  err_q       <= addr_fault;
`else
                  mar_q       <= bus.req_addr & AddrMask;
`endif
                  if (addr_fault) begin
                     mbr_q       <= '0;
                     rsp_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end else if (bus.req_write) begin
                     mem_we_q <= 1'b1;
                     state_q  <= StWrite;
                  end else begin
                     state_q <= StRdAddr;
                  end
               end
            end
            StWrite: begin
               mem_we_q    <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StRdAddr: begin
               state_q <= StRdCapt;
            end
            StRdCapt: begin
               mbr_q       <= bus.mem_data_out;
               rsp_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               mem_we_q    <= 1'b0;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign bus.req_ready        = req_ready_q;
   assign bus.rsp_valid        = rsp_valid_q;
   assign bus.rsp_data         = mbr_q;
   assign bus.mem_addr         = mar_q;
   assign bus.mem_data_in      = mbr_q;
   assign bus.mem_write_enable = mem_we_q;

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Bus initiator that drives the main memory's responder port on behalf of the CPU datapath. Holds the MAR and MBR, accepts one load or store request at a time from the control unit, and sequences the memory's registered read latency. Returns the read data, or echoes the written data, on a valid/ready response channel. It sits between the control FSM and the 16Ki x 16 main memory.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, request/memory address width
- MEM_DEPTH, 16384, number of implemented memory words
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  load data, or store data echo
- rsp_error  out  1  address fault (see Configuration)
- mem_addr  out  ADDR_W  to memory addr
- mem_data_in  out  DATA_W  to memory data_in
- mem_write_enable  out  1  to memory write_enable
- mem_data_out  in  DATA_W  from memory data_out, valid one edge after the address is presented with write_enable low

## Operation
- States: IDLE, WRITE, RD_ADDR, RD_CAPT, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready: MAR<=req_addr, MBR<=req_wdata, err<=0; next state WRITE if req_write, else RD_ADDR.
- WRITE: mem_write_enable=1, mem_addr=MAR, mem_data_in=MBR; next state DONE.
- RD_ADDR: mem_write_enable=0, mem_addr=MAR; the memory samples at the end of this cycle; next state RD_CAPT.
- RD_CAPT: MBR<=mem_data_out; next state DONE.
- DONE: rsp_valid=1, rsp_data=MBR, rsp_error=err. These are held stable until rsp_ready, then the state returns to IDLE.
- mem_* outputs are decoded only from the state register, MAR and MBR, never combinationally from req_*. Outside WRITE, mem_write_enable=0.
- mem_addr=MAR in every state; mem_data_in=MBR in every state.
- Only one transaction is in flight. req_valid outside IDLE is ignored, and the requester must hold it.

## Timing
- Reset (reset_n low, asynchronous): state=IDLE, MAR=0, MBR=0, err=0. Therefore rsp_valid=0, rsp_data=0, rsp_error=0, mem_write_enable=0, mem_addr=0, mem_data_in=0, and req_ready=1. Requests are not accepted while reset_n is low.
- Store latency: the accept edge is E. The memory write occurs at E+1. rsp_valid is high from E+2.
- Load latency: the accept edge is E. The memory samples at E+1, MBR captures at E+2, and rsp_valid is high from E+3.
- With rsp_ready tied high, throughput is one store per 3 cycles and one load per 4 cycles.
- Response and acceptance never occur in the same cycle; the next accept is possible at the edge after the DONE handshake.
- Reset mid-operation aborts immediately. If reset is asserted during WRITE, mem_write_enable drops asynchronously and no write is guaranteed to complete. If reset is asserted during a read, no response is produced.
- Address arithmetic: addresses are unsigned; wrap and fault handling is per Configuration.

## Configuration
- MEM_ADDR_CHECK_EN defined:
  - At accept, if req_addr >= MEM_DEPTH, err<=1, MBR<=0, and the next state is DONE directly.
  - No memory strobe is issued, and the response is at E+1 with rsp_error=1 and rsp_data=0.
- MEM_ADDR_CHECK_EN undefined:
  - MAR<=req_addr modulo MEM_DEPTH, i.e. the low log2(MEM_DEPTH) bits with the upper bits zeroed, so out-of-range addresses alias.
  - rsp_error is tied to 0.

## Test plan
- Reset: assert reset_n=0 mid-simulation -> rsp_valid=0, mem_write_enable=0, mem_addr=0, req_ready=1 asynchronously.
- Store then load: store 0x1234 to 0x0005, then load 0x0005 -> rsp_valid at E+2 for the store with rsp_data=0x1234, and at E+3 for the load with rsp_data=0x1234. mem_write_enable is high for exactly one cycle.
- Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data are held, req_ready=0, and no new request is accepted until the handshake.
- Boundary: store/load 0xBEEF at 0x3FFF -> the load returns 0xBEEF. Then access 0x4000:
  - with MEM_ADDR_CHECK_EN: rsp_error=1, rsp_data=0, no mem_write_enable pulse.
  - without: 0x4000 aliases to 0x0000.
- Reset mid-read: pulse reset_n low during RD_CAPT -> no rsp_valid, MBR=0, and a subsequent load completes normally.
- Streaming: 8 alternating store/load pairs to 0x0000-0x0007 with rsp_ready=1 -> every load returns its paired data, and the cycle count equals 8*(3+4).
